perceptron_bpred: RTL and testbench

PERCEPTRON_BPRED -- requirements
Module: perceptron_bpred

---
 rtl/bpred_pkg.sv | 33 +++
 rtl/bpred_weight_bank.sv | 38 +++
 rtl/perceptron_bpred.sv | 181 ++++++++++++++++++
 tb/tb_perceptron_bpred.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpred_pkg.sv
// Shared types and helpers for the perceptron branch predictor.
// Holds the FSM state type, accumulator sizing and saturating weight step.
package bpred_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COMPUTE  = 2'd1,
        ST_WAIT_RES = 2'd2,
        ST_TRAIN    = 2'd3
    } bpred_state_t;

    // Enough headroom for HIST_LEN+1 full-scale weights of either sign.
    function automatic int sum_width(input int weight_w, input int hist_len);
        return weight_w + $clog2(hist_len + 1);
    endfunction

    // Weights are carried as 8-bit signed here; the caller truncates back to WEIGHT_W.
    function automatic logic signed [7:0] sat_step(input logic signed [7:0] w,
                                                   input logic              up,
                                                   input int                weight_w);
        logic signed [8:0] lim;
        logic signed [8:0] nxt;
        lim = $signed(9'((1 << (weight_w - 1)) - 1));
        nxt = up ? ($signed({w[7], w}) + 9'sd1) : ($signed({w[7], w}) - 9'sd1);
        if (nxt > lim) begin
            nxt = lim;
        end else if (nxt < -lim) begin
            nxt = -lim;
        end
        return nxt[7:0];
    endfunction

endpackage

// File: rtl/bpred_weight_bank.sv
// Perceptron weight store: NUM_PERC rows of NUM_W signed weights, async clear to zero.
// Latency: combinational read, write lands on the next clock edge; no backpressure.
// Backpressure: none, the owning FSM serialises all accesses.
module bpred_weight_bank #(
    parameter int NUM_PERC = 8,
    parameter int NUM_W    = 8,
    parameter int WEIGHT_W = 8,
    parameter int IDX_W    = 3,
    parameter int SEL_W    = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [IDX_W-1:0]           rd_idx,
    input  logic [SEL_W-1:0]           rd_sel,
    output logic signed [WEIGHT_W-1:0] rd_dat,
    input  logic                       wr_en,
    input  logic [IDX_W-1:0]           wr_idx,
    input  logic [SEL_W-1:0]           wr_sel,
    input  logic signed [WEIGHT_W-1:0] wr_dat
);

    logic signed [WEIGHT_W-1:0] weights [NUM_PERC][NUM_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NUM_PERC; p++) begin
                for (int s = 0; s < NUM_W; s++) begin
                    weights[p][s] <= '0;
                end
            end
        end else if (wr_en) begin
            weights[wr_idx][wr_sel] <= wr_dat;
        end
    end

    assign rd_dat = weights[rd_idx][rd_sel];

endmodule

// File: rtl/perceptron_bpred.sv
// Perceptron branch predictor with a serial dot product and serial training; BPRED_STATS_EN adds counters.
// Latency: prediction HIST_LEN+2 cycles after the request; training adds HIST_LEN+1 cycles before done.
// Backpressure: req_ready is low for the whole transaction; flush abandons it without side effects.
module perceptron_bpred
    import bpred_pkg::*;
#(
    parameter int HIST_LEN = 7,
    parameter int WEIGHT_W = 8,
    parameter int NUM_PERC = 8,
    parameter int PC_W     = 8,
    parameter int THETA    = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [PC_W-1:0] req_pc,
    output logic            pred_valid,
    output logic            pred_taken,
    input  logic            res_valid,
    input  logic            res_taken,
    input  logic            flush,
    output logic            done
`ifdef BPRED_STATS_EN
    ,
    output logic [15:0]     stat_pred,
    output logic [15:0]     stat_mispred
`endif
);

    localparam int NUM_W = HIST_LEN + 1;
    localparam int IDX_W = (NUM_PERC > 1) ? $clog2(NUM_PERC) : 1;
    localparam int CNT_W = $clog2(NUM_W);
    localparam int SUM_W = sum_width(WEIGHT_W, HIST_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HIST_LEN);
    localparam logic [31:0]      THETA_U  = 32'(THETA);

    bpred_state_t               state;
    logic [IDX_W-1:0]           idx;
    logic [IDX_W-1:0]           idx_next;
    logic [CNT_W-1:0]           cnt;
    logic signed [SUM_W-1:0]    sum;
    logic signed [SUM_W-1:0]    sum_acc;
    logic signed [SUM_W-1:0]    w_term;
    logic [SUM_W-1:0]           sum_abs;
    logic [HIST_LEN-1:0]        history;
    logic [HIST_LEN-1:0]        hist_next;
    logic [HIST_LEN:0]          x_vec;
    logic                       x_pos;
    logic                       train_t;
    logic                       shift_bit;
    logic                       mispred;
    logic                       low_conf;
    logic signed [WEIGHT_W-1:0] rd_dat;
    logic signed [WEIGHT_W-1:0] wr_dat;
    logic signed [7:0]          rd_ext;
    logic                       wr_en;

    // Slot 0 is the bias, whose input is a constant +1; slot i+1 pairs with history bit i.
    always_comb begin
        idx_next  = IDX_W'(req_pc >> 2) ^ IDX_W'(history);
        x_vec     = {history, 1'b1};
        x_pos     = x_vec[cnt];
        w_term    = {{(SUM_W - WEIGHT_W){rd_dat[WEIGHT_W-1]}}, rd_dat};
        sum_acc   = x_pos ? (sum + w_term) : (sum - w_term);
        sum_abs   = sum[SUM_W-1] ? $unsigned(-sum) : $unsigned(sum);
        mispred   = (res_taken != pred_taken);
        low_conf  = ({{(32 - SUM_W){1'b0}}, sum_abs} <= THETA_U);
        shift_bit = (state == ST_TRAIN) ? train_t : res_taken;
        hist_next = HIST_LEN'({history, shift_bit});
        rd_ext    = 8'(rd_dat);
        wr_dat    = WEIGHT_W'(sat_step(rd_ext, train_t == x_pos, WEIGHT_W));
        wr_en     = (state == ST_TRAIN) && !flush;
    end

    assign req_ready = (state == ST_IDLE);

    bpred_weight_bank #(
        .NUM_PERC (NUM_PERC),
        .NUM_W    (NUM_W),
        .WEIGHT_W (WEIGHT_W),
        .IDX_W    (IDX_W),
        .SEL_W    (CNT_W)
    ) u_bank (
        .clk    (clk),
        .rst_n  (rst_n),
        .rd_idx (idx),
        .rd_sel (cnt),
        .rd_dat (rd_dat),
        .wr_en  (wr_en),
        .wr_idx (idx),
        .wr_sel (cnt),
        .wr_dat (wr_dat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            idx        <= '0;
            cnt        <= '0;
            sum        <= '0;
            history    <= '0;
            train_t    <= 1'b0;
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            done       <= 1'b0;
        end else begin
            pred_valid <= 1'b0;
            done       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        idx   <= idx_next;
                        cnt   <= '0;
                        sum   <= '0;
                        state <= ST_COMPUTE;
                    end
                end
                ST_COMPUTE: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else begin
                        sum <= sum_acc;
                        if (cnt == CNT_LAST) begin
                            pred_valid <= 1'b1;
                            pred_taken <= !sum_acc[SUM_W-1];
                            state      <= ST_WAIT_RES;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_WAIT_RES: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else if (res_valid) begin
                        train_t <= res_taken;
                        if (mispred || low_conf) begin
                            cnt   <= '0;
                            state <= ST_TRAIN;
                        end else begin
                            done    <= 1'b1;
                            history <= hist_next;
                            state   <= ST_IDLE;
                        end
                    end
                end
                ST_TRAIN: begin
                    // History only moves on retire so every slot trains against the same inputs.
                    if (flush) begin
                        state <= ST_IDLE;
                    end else if (cnt == CNT_LAST) begin
                        done    <= 1'b1;
                        history <= hist_next;
                        state   <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef BPRED_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_pred    <= '0;
            stat_mispred <= '0;
        end else begin
            if (pred_valid) begin
                stat_pred <= stat_pred + 16'd1;
            end
            if ((state == ST_WAIT_RES) && res_valid && !flush && mispred) begin
                stat_mispred <= stat_mispred + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_perceptron_bpred.sv
// Directed bench for perceptron_bpred: default instance plus a high-THETA instance for saturation.
// Expected values are hand-derived from the weight/history arithmetic of each scenario.
module tb_perceptron_bpred;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_ready, pred_valid, pred_taken;
    logic       res_valid, res_taken, flush, done;
    logic [7:0] req_pc;
    logic       s_req_valid, s_req_ready, s_pred_valid, s_pred_taken;
    logic       s_res_valid, s_res_taken, s_flush, s_done;
    logic [7:0] s_req_pc;
`ifdef BPRED_STATS_EN
    logic [15:0] stat_pred, stat_mispred, s_stat_pred, s_stat_mispred;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    perceptron_bpred dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_pc       (req_pc),
        .pred_valid   (pred_valid),
        .pred_taken   (pred_taken),
        .res_valid    (res_valid),
        .res_taken    (res_taken),
        .flush        (flush),
        .done         (done)
`ifdef BPRED_STATS_EN
        ,
        .stat_pred    (stat_pred),
        .stat_mispred (stat_mispred)
`endif
    );

    perceptron_bpred #(.THETA(2000)) dut_sat (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (s_req_valid),
        .req_ready    (s_req_ready),
        .req_pc       (s_req_pc),
        .pred_valid   (s_pred_valid),
        .pred_taken   (s_pred_taken),
        .res_valid    (s_res_valid),
        .res_taken    (s_res_taken),
        .flush        (s_flush),
        .done         (s_done)
`ifdef BPRED_STATS_EN
        ,
        .stat_pred    (s_stat_pred),
        .stat_mispred (s_stat_mispred)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 1'b0; req_pc = '0; res_valid = 1'b0; res_taken = 1'b0; flush = 1'b0;
        s_req_valid = 1'b0; s_req_pc = '0; s_res_valid = 1'b0; s_res_taken = 1'b0; s_flush = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Drives one full transaction on the default instance and reports what it saw.
    task automatic run_txn(input logic [7:0] pc, input logic outcome,
                           output int plat, output logic ptaken, output int dlat, output int dcnt);
        req_pc = pc;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        plat = 1;
        while (!pred_valid && plat < 40) begin
            tick();
            plat++;
        end
        ptaken = pred_taken;
        res_taken = outcome;
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        dlat = 1;
        while (!done && dlat < 40) begin
            tick();
            dlat++;
        end
        dcnt = done ? 1 : 0;
        repeat (3) begin
            tick();
            if (done) dcnt++;
        end
    endtask

    task automatic test_reset();
        int nz;
        do_reset();
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
        n_tests++; if (pred_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pred_valid: got %b expected 0", pred_valid); end
        n_tests++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_pred_taken: got %b expected 0", pred_taken); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_tests++; if (dut.history !== 7'h00) begin n_fail++; $display("FAIL reset_history: got %h expected 00", dut.history); end
        nz = 0;
        for (int p = 0; p < 8; p++)
            for (int s = 0; s < 8; s++)
                if (dut.u_bank.weights[p][s] !== 8'sd0) nz++;
        n_tests++; if (nz !== 0) begin n_fail++; $display("FAIL reset_weights: %0d nonzero expected 0", nz); end
    endtask

    task automatic test_first_prediction();
        int plat, dlat, dcnt;
        logic pt;
        run_txn(8'h00, 1'b1, plat, pt, dlat, dcnt);
        n_tests++; if (plat !== 9) begin n_fail++; $display("FAIL first_pred_latency: got %0d expected 9", plat); end
        n_tests++; if (pt !== 1'b1) begin n_fail++; $display("FAIL first_pred_taken: got %b expected 1", pt); end
        n_tests++; if (dlat !== 9) begin n_fail++; $display("FAIL first_train_done_latency: got %0d expected 9", dlat); end
        n_tests++; if (dcnt !== 1) begin n_fail++; $display("FAIL first_done_pulses: got %0d expected 1", dcnt); end
        n_tests++; if (dut.u_bank.weights[0][0] !== 8'sd1) begin n_fail++; $display("FAIL first_bias: got %0d expected 1", dut.u_bank.weights[0][0]); end
        for (int s = 1; s < 8; s++) begin
            n_tests++;
            if (dut.u_bank.weights[0][s] !== -8'sd1) begin
                n_fail++; $display("FAIL first_w%0d: got %0d expected -1", s - 1, dut.u_bank.weights[0][s]);
            end
        end
        n_tests++; if (dut.history !== 7'h01) begin n_fail++; $display("FAIL first_history: got %h expected 01", dut.history); end
    endtask

    // Not-taken at history 0: sums go 0, -8, -16; the third is confident and correct.
    task automatic test_no_train();
        int plat, dlat, dcnt;
        logic pt;
        do_reset();
        run_txn(8'h00, 1'b0, plat, pt, dlat, dcnt);
        n_tests++; if (pt !== 1'b1 || dlat !== 9) begin n_fail++; $display("FAIL notrain_txn1: taken %b lat %0d expected 1/9", pt, dlat); end
        run_txn(8'h00, 1'b0, plat, pt, dlat, dcnt);
        n_tests++; if (pt !== 1'b0 || dlat !== 9) begin n_fail++; $display("FAIL notrain_txn2: taken %b lat %0d expected 0/9", pt, dlat); end
        run_txn(8'h00, 1'b0, plat, pt, dlat, dcnt);
        n_tests++; if (pt !== 1'b0) begin n_fail++; $display("FAIL notrain_pred: got %b expected 0", pt); end
        n_tests++; if (dlat !== 1) begin n_fail++; $display("FAIL notrain_done_latency: got %0d expected 1", dlat); end
        n_tests++; if (dcnt !== 1) begin n_fail++; $display("FAIL notrain_done_pulses: got %0d expected 1", dcnt); end
        n_tests++; if (dut.u_bank.weights[0][0] !== -8'sd2) begin n_fail++; $display("FAIL notrain_bias: got %0d expected -2", dut.u_bank.weights[0][0]); end
        n_tests++; if (dut.u_bank.weights[0][7] !== 8'sd2) begin n_fail++; $display("FAIL notrain_w6: got %0d expected 2", dut.u_bank.weights[0][7]); end
        n_tests++; if (dut.history !== 7'h00) begin n_fail++; $display("FAIL notrain_history: got %h expected 00", dut.history); end
    endtask

    // Stray res_valid in IDLE and a second req_valid mid-COMPUTE (pc 0x04 -> idx 1, which would predict taken).
    task automatic test_ignored_inputs();
        int plat;
        int seen_done;
        seen_done = 0;
        res_taken = 1'b1;
        res_valid = 1'b1;
        repeat (3) begin
            tick();
            if (done) seen_done++;
        end
        res_valid = 1'b0;
        n_tests++; if (seen_done !== 0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL idle_res_ignored: done %0d ready %b expected 0/1", seen_done, req_ready); end
        n_tests++; if (dut.history !== 7'h00) begin n_fail++; $display("FAIL idle_res_history: got %h expected 00", dut.history); end
        req_pc = 8'h00;
        req_valid = 1'b1;
        tick();
        req_pc = 8'h04;
        plat = 1;
        while (!pred_valid && plat < 40) begin
            tick();
            plat++;
            if (plat == 4) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        n_tests++; if (plat !== 9) begin n_fail++; $display("FAIL busy_req_latency: got %0d expected 9", plat); end
        n_tests++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL busy_req_taken: got %b expected 0", pred_taken); end
        res_taken = 1'b0;
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL busy_req_done: got %b expected 1", done); end
        tick();
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL busy_req_idle: got %b expected 1", req_ready); end
    endtask

    task automatic test_flush();
        int plat;
        int seen;
        req_pc = 8'h00;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL flush_compute_idle: got %b expected 1", req_ready); end
        seen = 0;
        repeat (12) begin
            if (pred_valid || done) seen++;
            tick();
        end
        n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL flush_compute_quiet: got %0d pulses expected 0", seen); end
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        plat = 1;
        while (!pred_valid && plat < 40) begin
            tick();
            plat++;
        end
        n_tests++; if (plat !== 9 || pred_taken !== 1'b0) begin n_fail++; $display("FAIL flush_wait_pred: lat %0d taken %b expected 9/0", plat, pred_taken); end
        flush = 1'b1;
        res_taken = 1'b1;
        res_valid = 1'b1;
        tick();
        flush = 1'b0;
        res_valid = 1'b0;
        n_tests++; if (req_ready !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL flush_wait_idle: ready %b done %b expected 1/0", req_ready, done); end
        seen = 0;
        repeat (12) begin
            if (done) seen++;
            tick();
        end
        n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL flush_wait_done: got %0d expected 0", seen); end
        n_tests++; if (dut.u_bank.weights[0][0] !== -8'sd2) begin n_fail++; $display("FAIL flush_bias: got %0d expected -2", dut.u_bank.weights[0][0]); end
        n_tests++; if (dut.u_bank.weights[0][1] !== 8'sd2) begin n_fail++; $display("FAIL flush_w0: got %0d expected 2", dut.u_bank.weights[0][1]); end
        n_tests++; if (dut.history !== 7'h00) begin n_fail++; $display("FAIL flush_history: got %h expected 00", dut.history); end
    endtask

    task automatic test_reset_mid_train();
        int plat, dlat, dcnt, nz;
        logic pt;
        req_pc = 8'h00;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        plat = 1;
        while (!pred_valid && plat < 40) begin
            tick();
            plat++;
        end
        res_taken = 1'b1;
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (req_ready !== 1'b1 || pred_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_outputs: ready %b pred %b expected 1/0", req_ready, pred_valid); end
        n_tests++; if (pred_taken !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midrst_taken_done: taken %b done %b expected 0/0", pred_taken, done); end
        n_tests++; if (dut.history !== 7'h00) begin n_fail++; $display("FAIL midrst_history: got %h expected 00", dut.history); end
        nz = 0;
        for (int p = 0; p < 8; p++)
            for (int s = 0; s < 8; s++)
                if (dut.u_bank.weights[p][s] !== 8'sd0) nz++;
        n_tests++; if (nz !== 0) begin n_fail++; $display("FAIL midrst_weights: %0d nonzero expected 0", nz); end
        tick();
        rst_n = 1'b1;
        tick();
        run_txn(8'h00, 1'b1, plat, pt, dlat, dcnt);
        n_tests++; if (plat !== 9 || pt !== 1'b1) begin n_fail++; $display("FAIL midrst_next_pred: lat %0d taken %b expected 9/1", plat, pt); end
    endtask

`ifdef BPRED_STATS_EN
    // Mispredicts: first pc0 (fresh, taken vs not-taken), then fresh idx 1 and idx 2.
    task automatic test_stats();
        int plat, dlat, dcnt;
        logic pt;
        logic [7:0] pcs [10];
        pcs = '{8'h00, 8'h00, 8'h00, 8'h04, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        do_reset();
        for (int k = 0; k < 10; k++) run_txn(pcs[k], 1'b0, plat, pt, dlat, dcnt);
        n_tests++; if (stat_pred !== 16'd10) begin n_fail++; $display("FAIL stat_pred: got %0d expected 10", stat_pred); end
        n_tests++; if (stat_mispred !== 16'd3) begin n_fail++; $display("FAIL stat_mispred: got %0d expected 3", stat_mispred); end
    endtask
`endif

    // THETA above any reachable |sum| forces training every time; pc tracks history to pin idx 0.
    task automatic test_saturation();
        logic [6:0] hist;
        int         wait_cnt;
        int         dones;
        hist = '0;
        dones = 0;
        for (int k = 1; k <= 200; k++) begin
            s_req_pc = {3'b000, hist[2:0], 2'b00};
            s_req_valid = 1'b1;
            tick();
            s_req_valid = 1'b0;
            wait_cnt = 0;
            while (!s_pred_valid && wait_cnt < 40) begin
                tick();
                wait_cnt++;
            end
            s_res_taken = 1'b1;
            s_res_valid = 1'b1;
            tick();
            s_res_valid = 1'b0;
            wait_cnt = 0;
            while (!s_done && wait_cnt < 40) begin
                tick();
                wait_cnt++;
            end
            if (s_done) dones++;
            tick();
            hist = {hist[5:0], 1'b1};
            if (k == 127) begin
                n_tests++; if (dut_sat.u_bank.weights[0][0] !== 8'sd127) begin n_fail++; $display("FAIL sat_bias_127: got %0d expected 127", dut_sat.u_bank.weights[0][0]); end
            end
            if (k == 128) begin
                n_tests++; if (dut_sat.u_bank.weights[0][0] !== 8'sd127) begin n_fail++; $display("FAIL sat_bias_nowrap: got %0d expected 127", dut_sat.u_bank.weights[0][0]); end
            end
        end
        n_tests++; if (dones !== 200) begin n_fail++; $display("FAIL sat_done_count: got %0d expected 200", dones); end
        n_tests++; if (dut_sat.u_bank.weights[0][0] !== 8'sd127) begin n_fail++; $display("FAIL sat_bias_final: got %0d expected 127", dut_sat.u_bank.weights[0][0]); end
        n_tests++; if (dut_sat.u_bank.weights[0][1] !== 8'sd127) begin n_fail++; $display("FAIL sat_w0_final: got %0d expected 127", dut_sat.u_bank.weights[0][1]); end
        n_tests++; if (dut_sat.history !== 7'h7F) begin n_fail++; $display("FAIL sat_history: got %h expected 7f", dut_sat.history); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_first_prediction();
        test_no_train();
        test_ignored_inputs();
        test_flush();
        test_reset_mid_train();
`ifdef BPRED_STATS_EN
        test_stats();
`endif
        do_reset();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
